// File: rtl/contra_pkg.sv
// Shared bullet-pool types and screen constants for the sprite pipeline.
// Pure declarations: no latency, no flow control.
package contra_pkg;

    localparam int NUM_BULLET_SLOTS = 10;
    localparam int SCREEN_W         = 640;
    localparam int SCREEN_H         = 480;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } player_id_t;

    typedef struct packed {
        logic       active;
        logic       owner;
        logic       dir;
        logic [9:0] x;
        logic [9:0] y;
    } bullet_slot_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the last winner loses the next tie.
// Combinational grant, rr_last updates on the edge after advance; no backpressure.
module rr_arbiter2
    import contra_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    player_id_t rr_last;

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11)
            grant = (rr_last == P2) ? 2'b01 : 2'b10;
        else
            grant = req;
    end

    always_ff @(posedge clk) begin
        if (reset)
            rr_last <= P2;
        else if (advance)
            rr_last <= grant[1] ? P2 : P1;
    end

endmodule

// File: rtl/bullet_slot_scheduler.sv
// Bullet slot pool: arbitrates fire requests, allocates slots, moves/frees bullets per frame.
// 1-cycle registered latency; a request with no free slot simply waits (held level request).
// Optional per-player fire cooldown enabled by defining BULLET_COOLDOWN_EN.
module bullet_slot_scheduler #(
    parameter int NUM_SLOTS = contra_pkg::NUM_BULLET_SLOTS,
    parameter int SPEED     = 4,
    parameter int COOLDOWN  = 8,
    parameter int SCREEN_W  = contra_pkg::SCREEN_W
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_tick,
    input  logic [1:0]              fire_req,
    input  logic [9:0]              p1_x,
    input  logic [9:0]              p2_x,
    input  logic [9:0]              p1_y,
    input  logic [9:0]              p2_y,
    input  logic                    p1_dir,
    input  logic                    p2_dir,
    input  logic [NUM_SLOTS-1:0]    hit,
    output logic [1:0]              fire_grant,
    output logic [NUM_SLOTS-1:0]    slot_active,
    output logic [NUM_SLOTS-1:0]    slot_owner,
    output logic [NUM_SLOTS*10-1:0] slot_x,
    output logic [NUM_SLOTS*10-1:0] slot_y,
    output logic                    full
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic signed [10:0] SPEED_S = 11'(SPEED);
    localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W - 1);

    if (COOLDOWN < 0 || COOLDOWN > 15) begin : g_cd_range
        $error("COOLDOWN must fit the 4-bit cooldown counter");
    end

    contra_pkg::bullet_slot_t slot_q [NUM_SLOTS];
    contra_pkg::bullet_slot_t slot_d [NUM_SLOTS];

    logic                 any_free;
    logic [IDX_W-1:0]     free_idx;
    logic [1:0]           elig;
    logic [1:0]           arb_grant;
    logic                 do_grant;
    logic [1:0]           grant_q;
    logic                 full_q;
    logic [NUM_SLOTS-1:0] next_active;

    // Free mask comes from registered state, so a slot freed this cycle waits a cycle.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_q[i].active) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

`ifdef BULLET_COOLDOWN_EN
    logic [3:0] cd_q [2];

    always_comb begin
        elig = fire_req & {(cd_q[1] == 4'd0), (cd_q[0] == 4'd0)};
    end

    // A grant reloads the counter and overrides a coincident tick decrement.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cd_q[0] <= 4'd0;
            cd_q[1] <= 4'd0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (do_grant && arb_grant[p])
                    cd_q[p] <= 4'(COOLDOWN);
                else if (frame_tick && cd_q[p] != 4'd0)
                    cd_q[p] <= cd_q[p] - 4'd1;
            end
        end
    end
`else
    always_comb begin
        elig = fire_req;
    end
`endif

    rr_arbiter2 u_arb (
        .clk     (Clk),
        .reset   (Reset),
        .req     (elig),
        .advance (do_grant),
        .grant   (arb_grant)
    );

    assign do_grant = any_free & (|arb_grant);

    always_comb begin
        logic signed [10:0] nx;
        nx          = '0;
        next_active = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_d[i] = slot_q[i];
            nx = slot_q[i].dir ? ($signed({1'b0, slot_q[i].x}) + SPEED_S)
                               : ($signed({1'b0, slot_q[i].x}) - SPEED_S);
            if (slot_q[i].active) begin
                if (hit[i])
                    slot_d[i].active = 1'b0;
                else if (frame_tick) begin
                    if (nx < 0 || nx > X_MAX)
                        slot_d[i].active = 1'b0;
                    else
                        slot_d[i].x = nx[9:0];
                end
            end
        end
        // The allocated slot was inactive, so it is never moved on its spawn cycle.
        if (do_grant) begin
            slot_d[free_idx].active = 1'b1;
            slot_d[free_idx].owner  = arb_grant[1];
            slot_d[free_idx].dir    = arb_grant[1] ? p2_dir : p1_dir;
            slot_d[free_idx].x      = arb_grant[1] ? p2_x : p1_x;
            slot_d[free_idx].y      = arb_grant[1] ? p2_y : p1_y;
        end
        for (int i = 0; i < NUM_SLOTS; i++)
            next_active[i] = slot_d[i].active;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SLOTS; i++)
                slot_q[i] <= '0;
            grant_q <= 2'b00;
            full_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++)
                slot_q[i] <= slot_d[i];
            grant_q <= do_grant ? arb_grant : 2'b00;
            full_q  <= &next_active;
        end
    end

    always_comb begin
        slot_active = '0;
        slot_owner  = '0;
        slot_x      = '0;
        slot_y      = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_active[i]      = slot_q[i].active;
            slot_owner[i]       = slot_q[i].owner;
            slot_x[10*i +: 10]  = slot_q[i].x;
            slot_y[10*i +: 10]  = slot_q[i].y;
        end
    end

    assign fire_grant = grant_q;
    assign full       = full_q;

endmodule

// File: tb/tb_bullet_slot_scheduler.sv
// Directed, table-driven bench for bullet_slot_scheduler (default build and BULLET_COOLDOWN_EN build).
module tb_bullet_slot_scheduler;

    localparam int N = 10;

    logic           Clk = 1'b0;
    logic           Reset;
    logic           frame_tick;
    logic [1:0]     fire_req;
    logic [9:0]     p1_x, p2_x, p1_y, p2_y;
    logic           p1_dir, p2_dir;
    logic [N-1:0]   hit;
    logic [1:0]     fire_grant;
    logic [N-1:0]   slot_active;
    logic [N-1:0]   slot_owner;
    logic [N*10-1:0] slot_x;
    logic [N*10-1:0] slot_y;
    logic           full;

    int compared   = 0;
    int mismatched = 0;

    bullet_slot_scheduler dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .fire_req    (fire_req),
        .p1_x        (p1_x),
        .p2_x        (p2_x),
        .p1_y        (p1_y),
        .p2_y        (p2_y),
        .p1_dir      (p1_dir),
        .p2_dir      (p2_dir),
        .hit         (hit),
        .fire_grant  (fire_grant),
        .slot_active (slot_active),
        .slot_owner  (slot_owner),
        .slot_x      (slot_x),
        .slot_y      (slot_y),
        .full        (full)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       rst;
        logic       tick;
        logic [1:0] req;
        logic [9:0] hit;
        logic [1:0] g;
        logic [9:0] act;
        logic [9:0] own;
        int         si;
        logic [9:0] sx;
        logic [9:0] sy;
    } vec_t;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [9:0] sx_of(input int i);
        return slot_x[10*i +: 10];
    endfunction

    function automatic logic [9:0] sy_of(input int i);
        return slot_y[10*i +: 10];
    endfunction

    task automatic do_reset();
        Reset = 1'b1; fire_req = 2'b00; frame_tick = 1'b0; hit = '0;
        step();
        Reset = 1'b0;
    endtask

    initial begin
        vec_t tbl [13];
        int   gcount;

        Reset = 1'b1; frame_tick = 1'b0; fire_req = 2'b00; hit = '0;
        p1_x = 10'd100; p1_y = 10'd200; p1_dir = 1'b1;
        p2_x = 10'd300; p2_y = 10'd50;  p2_dir = 1'b0;

        //           rst   tick  req    hit      grant  active   owner&act slot x       y
        tbl[0]  = '{1'b1, 1'b0, 2'b11, 10'h000, 2'b00, 10'h000, 10'h000, 0, 10'd0,   10'd0};
        tbl[1]  = '{1'b0, 1'b0, 2'b01, 10'h000, 2'b01, 10'h001, 10'h000, 0, 10'd100, 10'd200};
        tbl[2]  = '{1'b0, 1'b0, 2'b00, 10'h000, 2'b00, 10'h001, 10'h000, 0, 10'd100, 10'd200};
        tbl[3]  = '{1'b0, 1'b1, 2'b00, 10'h000, 2'b00, 10'h001, 10'h000, 0, 10'd104, 10'd200};
        tbl[4]  = '{1'b0, 1'b0, 2'b11, 10'h000, 2'b10, 10'h003, 10'h002, 1, 10'd300, 10'd50};
        tbl[5]  = '{1'b0, 1'b0, 2'b11, 10'h000, 2'b01, 10'h007, 10'h002, 2, 10'd100, 10'd200};
        tbl[6]  = '{1'b0, 1'b1, 2'b11, 10'h000, 2'b10, 10'h00F, 10'h00A, 3, 10'd300, 10'd50};
        tbl[7]  = '{1'b0, 1'b0, 2'b00, 10'h002, 2'b00, 10'h00D, 10'h008, 0, 10'd108, 10'd200};
        tbl[8]  = '{1'b0, 1'b0, 2'b10, 10'h000, 2'b10, 10'h00F, 10'h00A, 1, 10'd300, 10'd50};
        tbl[9]  = '{1'b0, 1'b1, 2'b00, 10'h001, 2'b00, 10'h00E, 10'h00A, 2, 10'd108, 10'd200};
        tbl[10] = '{1'b0, 1'b0, 2'b00, 10'h010, 2'b00, 10'h00E, 10'h00A, 3, 10'd296, 10'd50};
        tbl[11] = '{1'b0, 1'b0, 2'b01, 10'h004, 2'b01, 10'h00B, 10'h00A, 0, 10'd100, 10'd200};
        tbl[12] = '{1'b0, 1'b0, 2'b01, 10'h000, 2'b01, 10'h00F, 10'h00A, 2, 10'd100, 10'd200};

        step();
        check("reset_active", 32'(slot_active), 32'h0);
        check("reset_owner",  32'(slot_owner),  32'h0);
        check("reset_grant",  32'(fire_grant),  32'h0);
        check("reset_full",   32'(full),        32'h0);
        check("reset_x_or",   32'(|slot_x),     32'h0);
        check("reset_y_or",   32'(|slot_y),     32'h0);

`ifndef BULLET_COOLDOWN_EN
        for (int r = 0; r < 13; r++) begin
            Reset = tbl[r].rst; frame_tick = tbl[r].tick;
            fire_req = tbl[r].req; hit = tbl[r].hit;
            step();
            check($sformatf("vec%0d_grant", r),  32'(fire_grant), 32'(tbl[r].g));
            check($sformatf("vec%0d_active", r), 32'(slot_active), 32'(tbl[r].act));
            check($sformatf("vec%0d_owner", r),  32'(slot_owner & slot_active), 32'(tbl[r].own));
            check($sformatf("vec%0d_full", r),   32'(full), 32'(&tbl[r].act));
            check($sformatf("vec%0d_x", r),      32'(sx_of(tbl[r].si)), 32'(tbl[r].sx));
            check($sformatf("vec%0d_y", r),      32'(sy_of(tbl[r].si)), 32'(tbl[r].sy));
        end
        fire_req = 2'b00; frame_tick = 1'b0; hit = '0;

        // Screen-edge freeing in both directions, and landing exactly on x = 0.
        do_reset();
        p1_x = 10'd638; p1_dir = 1'b1; fire_req = 2'b01; step();
        p2_x = 10'd2;   p2_dir = 1'b0; fire_req = 2'b10; step();
        p2_x = 10'd4;                  fire_req = 2'b10; step();
        fire_req = 2'b00;
        check("edge_spawned", 32'(slot_active), 32'h007);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        check("edge_active_after_tick", 32'(slot_active), 32'h004);
        check("edge_x_zero", 32'(sx_of(2)), 32'd0);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        check("edge_left_exit", 32'(slot_active), 32'h000);

        // Fill the pool with both players holding requests.
        p1_x = 10'd100; p1_dir = 1'b1; p2_x = 10'd300; p2_dir = 1'b0;
        do_reset();
        fire_req = 2'b11;
        for (int i = 0; i < N; i++) begin
            step();
            check($sformatf("fill%0d_grant", i), 32'(fire_grant), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        check("fill_active", 32'(slot_active), 32'h3FF);
        check("fill_full", 32'(full), 32'd1);
        check("fill_owner", 32'(slot_owner), 32'h2AA);
        step();
        check("full_no_grant", 32'(fire_grant), 32'd0);
        hit = 10'h008; step(); hit = '0;
        check("hit3_no_grant", 32'(fire_grant), 32'd0);
        check("hit3_active", 32'(slot_active), 32'h3F7);
        check("hit3_not_full", 32'(full), 32'd0);
        step();
        check("refill_grant_p1", 32'(fire_grant), 32'd1);
        check("refill_active", 32'(slot_active), 32'h3FF);
        check("refill_owner", 32'(slot_owner), 32'h2A2);
        check("refill_x", 32'(sx_of(3)), 32'd100);
        fire_req = 2'b00;
`else
        // Cooldown: held p1 request, grants exactly 8 ticks apart.
        Reset = 1'b0; fire_req = 2'b01; step();
        check("cd_first_grant", 32'(fire_grant), 32'd1);
        gcount = 0;
        for (int k = 0; k < 7; k++) begin
            frame_tick = 1'b1; step(); gcount += (fire_grant != 2'b00) ? 1 : 0;
            frame_tick = 1'b0; step(); gcount += (fire_grant != 2'b00) ? 1 : 0;
        end
        check("cd_blocked_7_ticks", 32'(gcount), 32'd0);
        frame_tick = 1'b1; step();
        check("cd_tick8_no_grant", 32'(fire_grant), 32'd0);
        step();
        check("cd_grant_on_tick", 32'(fire_grant), 32'd1);
        check("cd_spawn_unmoved", 32'(sx_of(1)), 32'd100);
        check("cd_old_moved", 32'(sx_of(0)), 32'd136);
        frame_tick = 1'b0; step();
        gcount = 0;
        for (int k = 0; k < 7; k++) begin
            frame_tick = 1'b1; step(); gcount += (fire_grant != 2'b00) ? 1 : 0;
            frame_tick = 1'b0; step(); gcount += (fire_grant != 2'b00) ? 1 : 0;
        end
        check("cd_reload_blocked_7", 32'(gcount), 32'd0);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        check("cd_reload_tick8", 32'(fire_grant), 32'd0);
        step();
        check("cd_second_grant", 32'(fire_grant), 32'd1);
        check("cd_active", 32'(slot_active), 32'h007);
        fire_req = 2'b00;
`endif

        // Reset mid-operation with live bullets and requests held high.
        do_reset();
        fire_req = 2'b11;
        for (int i = 0; i < 5; i++) step();
`ifndef BULLET_COOLDOWN_EN
        check("pre_reset_active", 32'(slot_active), 32'h01F);
`endif
        Reset = 1'b1; step();
        check("mid_reset_active", 32'(slot_active), 32'h0);
        check("mid_reset_owner",  32'(slot_owner),  32'h0);
        check("mid_reset_grant",  32'(fire_grant),  32'h0);
        check("mid_reset_full",   32'(full),        32'h0);
        check("mid_reset_x",      32'(|slot_x),     32'h0);
        check("mid_reset_y",      32'(|slot_y),     32'h0);
        Reset = 1'b0; step();
        check("post_reset_tie_p1", 32'(fire_grant), 32'd1);
        check("post_reset_owner",  32'(slot_owner & slot_active), 32'h0);
        fire_req = 2'b00;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
